// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle RV32 datapath.
// Sequences one memory port, one ALU and IR/ALUOut/MDR.
module multicycle_control #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       irwrite,
  output logic       adrsrc,
  output logic       memread,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] resultsrc,
  output logic [1:0] immsel,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_r, is_ld, is_st, is_br;
  logic             mem_wait, limit_hit;

  // Opcode class decode.
  always_comb begin
    is_r  = (opcode == OP_R);
    is_ld = (opcode == OP_LD);
    is_st = (opcode == OP_ST);
    is_br = (opcode == OP_BR);
  end

  // Immediate type follows the opcode in every state.
  always_comb begin
    unique case (1'b1)
      is_st:   immsel = 2'b01;
      is_br:   immsel = 2'b10;
      default: immsel = 2'b00;
    endcase
  end

  // Next state, wait counter and Moore/handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pc_en       = 1'b0;
    irwrite     = 1'b0;
    adrsrc      = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 2'b00;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    resultsrc   = 2'b00;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    mem_wait    = 1'b0;
    limit_hit   = (WAIT_LIMIT != 0) && !mem_ready &&
                  (cnt_q == CNT_W'(WAIT_LIMIT - 1));
    case (state_q)
      S_FETCH: begin
        memread   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pc_en     = mem_ready;
        mem_wait  = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        unique case (1'b1)
          is_ld, is_st: state_d = S_MEMADR;
          is_r:         state_d = S_EXECR;
          is_br:        state_d = S_BEQ;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        unique case (1'b1)
          is_ld:   state_d = S_MEMREAD;
          is_st:   state_d = S_MEMWRITE;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMREAD: begin
        adrsrc   = 1'b1;
        memread  = 1'b1;
        mem_wait = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        mem_wait = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        pc_en   = zero;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (mem_wait && !mem_ready) begin
      if (limit_hit) begin
        mem_timeout = 1'b1;
        state_d     = S_FETCH;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (rst) begin
      state_d     = S_FETCH;
      cnt_d       = '0;
      pc_en       = 1'b0;
      irwrite     = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      regwrite    = 1'b0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
      adrsrc      = 1'b0;
      alusrca     = 2'b00;
      alusrcb     = 2'b10;
      aluop       = 2'b00;
      resultsrc   = 2'b10;
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: path-based model
// checked every cycle plus directed literal checks.
module tb_multicycle_control;

  localparam int WL = 16;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_IL = 7'b0010011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] opcode = OP_R;
  logic       pc_en, irwrite, adrsrc, memread, memwrite, regwrite;
  logic [1:0] alusrca, alusrcb, aluop, resultsrc, immsel;
  logic       illegal, mem_timeout;
  logic [3:0] state;

  multicycle_control #(.WAIT_LIMIT(WL), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .irwrite(irwrite),
    .adrsrc(adrsrc), .memread(memread), .memwrite(memwrite),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .resultsrc(resultsrc), .immsel(immsel),
    .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Instruction as a list of steps; nibble i is step i.
  function automatic int plen(input logic [6:0] op);
    case (op)
      OP_R:    return 4;
      OP_LD:   return 5;
      OP_ST:   return 4;
      OP_BR:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] pst(input logic [6:0] op, input int i);
    logic [19:0] p;
    case (op)
      OP_R:    p = 20'h01670;
      OP_LD:   p = 20'h01234;
      OP_ST:   p = 20'h01250;
      OP_BR:   p = 20'h01800;
      default: p = 20'h01000;
    endcase
    return p[19-4*i -: 4];
  endfunction

  function automatic logic [21:0] expv(input logic r, input logic [6:0] op,
                                      input logic z, input logic mr,
                                      input logic [3:0] st, input logic to);
    logic pc, ir, ad, mrd, mwr, rw, il, tt;
    logic [1:0] a, b, ao, rs, im;
    {pc, ir, ad, mrd, mwr, rw, il} = '0;
    {a, b, ao, rs} = '0;
    tt = to;
    im = (op == OP_ST) ? 2'd1 : (op == OP_BR) ? 2'd2 : 2'd0;
    case (st)
      4'd0: begin mrd = 1; b = 2; rs = 2; ir = mr; pc = mr; end
      4'd1: begin
        a = 1; b = 1;
        il = !(op == OP_R || op == OP_LD || op == OP_ST || op == OP_BR);
      end
      4'd2: begin a = 2; b = 1; end
      4'd3: begin ad = 1; mrd = 1; end
      4'd4: begin rs = 1; rw = 1; end
      4'd5: begin ad = 1; mwr = 1; end
      4'd6: begin a = 2; ao = 2; end
      4'd7: rw = 1;
      4'd8: begin a = 2; ao = 1; pc = z; end
      default: ;
    endcase
    if (r) begin
      {pc, ir, mrd, mwr, rw, il, tt} = '0;
      ad = 0; a = 0; b = 2; ao = 0; rs = 2;
    end
    return {pc, ir, ad, mrd, mwr, rw, a, b, ao, rs, im, il, tt, st};
  endfunction

  int m_idx = 0;
  int m_wait = 0;
  int ncyc = 0;

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin : cmp
    logic [3:0] st;
    logic mem, to;
    logic [21:0] e, g;
    st  = pst(opcode, m_idx);
    mem = (st == 4'd0 || st == 4'd3 || st == 4'd5);
    to  = mem && !mem_ready && (m_wait == WL - 1);
    e   = expv(rst, opcode, zero, mem_ready, st, to);
    g   = {pc_en, irwrite, adrsrc, memread, memwrite, regwrite,
           alusrca, alusrcb, aluop, resultsrc, immsel,
           illegal, mem_timeout, state};
    check($sformatf("cycle%0d_outputs", ncyc), 32'(g), 32'(e));
    ncyc++;
    if (rst) begin
      m_idx = 0; m_wait = 0;
    end else if (mem && !mem_ready) begin
      if (to) begin m_idx = 0; m_wait = 0; end
      else m_wait++;
    end else begin
      m_idx++;
      if (m_idx >= plen(opcode)) m_idx = 0;
      m_wait = 0;
    end
  end

  typedef struct {
    logic [3:0] st;
    logic pc, ir, ad, mrd, mwr, rw, il, to;
    logic [1:0] ao, rs;
  } obs_t;
  obs_t ob[$];

  task automatic cyc(input logic r, input logic mr, input logic zr);
    obs_t o;
    rst = r; mem_ready = mr; zero = zr;
    @(negedge clk);
    o.st = state; o.pc = pc_en; o.ir = irwrite; o.ad = adrsrc;
    o.mrd = memread; o.mwr = memwrite; o.rw = regwrite;
    o.il = illegal; o.to = mem_timeout; o.ao = aluop; o.rs = resultsrc;
    ob.push_back(o);
    @(posedge clk); #1;
  endtask

  // f: 0 state,1 pc,2 ir,3 adr,4 mrd,5 mwr,6 rw,7 il,8 to,9 aluop,10 rs
  function automatic logic [31:0] pat(input int f);
    logic [31:0] r;
    r = '0;
    foreach (ob[i]) begin
      case (f)
        0:  r = {r[27:0], ob[i].st};
        1:  r = {r[30:0], ob[i].pc};
        2:  r = {r[30:0], ob[i].ir};
        3:  r = {r[30:0], ob[i].ad};
        4:  r = {r[30:0], ob[i].mrd};
        5:  r = {r[30:0], ob[i].mwr};
        6:  r = {r[30:0], ob[i].rw};
        7:  r = {r[30:0], ob[i].il};
        8:  r = {r[30:0], ob[i].to};
        9:  r = {r[29:0], ob[i].ao};
        default: r = {r[29:0], ob[i].rs};
      endcase
    end
    return r;
  endfunction

  initial begin
    @(posedge clk); #1;
    cyc(1, 1, 0); cyc(1, 1, 0);
    check("reset_state", pat(0), 32'h00);
    check("reset_memread", pat(4), 32'h0);
    check("reset_irwrite", pat(2), 32'h0);

    ob.delete(); opcode = OP_R;
    repeat (4) cyc(0, 1, 0);
    check("rtype_states", pat(0), 32'h0167);
    check("rtype_regwrite", pat(6), 32'b0001);
    check("rtype_aluop", pat(9), 32'h08);

    ob.delete(); opcode = OP_LD;
    repeat (3) cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    repeat (2) cyc(0, 1, 0);
    check("load_states", pat(0), 32'h01233334);
    check("load_memread", pat(4), 32'b10011110);
    check("load_adrsrc", pat(3), 32'b00011110);
    check("load_regwrite", pat(6), 32'b00000001);
    check("load_resultsrc", pat(10), 32'h8001);

    ob.delete(); opcode = OP_BR;
    repeat (3) cyc(0, 1, 1);
    check("beq_taken_states", pat(0), 32'h018);
    check("beq_taken_pc_en", pat(1), 32'b101);
    ob.delete();
    repeat (3) cyc(0, 1, 0);
    check("beq_not_taken_states", pat(0), 32'h018);
    check("beq_not_taken_pc_en", pat(1), 32'b100);

    ob.delete(); opcode = OP_ST;
    repeat (3) cyc(0, 1, 0);
    repeat (17) cyc(0, 0, 0);
    check("store_to_memwrite", pat(5), 32'h1FFFE);
    check("store_to_pulse", pat(8), 32'h2);
    check("store_to_regwrite", pat(6), 32'h0);
    check("store_to_last_mw", 32'(ob[18].st), 32'd5);
    check("store_to_refetch", 32'(ob[19].st), 32'd0);

    ob.delete(); opcode = OP_IL;
    repeat (2) cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("illegal_states", pat(0), 32'h010);
    check("illegal_pulse", pat(7), 32'b010);

    ob.delete(); opcode = OP_ST;
    repeat (3) cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("rst_mw_states", pat(0), 32'h012550);
    check("rst_mw_memwrite", pat(5), 32'b000100);
    check("rst_mw_strobes", 32'({ob[4].pc, ob[4].ir, ob[4].mrd,
          ob[4].mwr, ob[4].rw, ob[4].il, ob[4].to}), 32'h0);

    ob.delete(); opcode = OP_R;
    cyc(1, 0, 0);
    repeat (15) cyc(0, 0, 0);
    repeat (2) cyc(0, 1, 0);
    check("ready_at_limit_pulse", pat(8), 32'h0);
    check("ready_at_limit_irwrite", 32'(ob[16].ir), 32'd1);
    check("ready_at_limit_next", 32'(ob[17].st), 32'd1);

    ob.delete();
    cyc(1, 0, 0);
    repeat (16) cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("fetch_to_pulse", pat(8), 32'b10);
    check("fetch_to_irwrite", pat(2), 32'h0);
    check("fetch_to_state", 32'(ob[17].st), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences the shared datapath of the multi-cycle RV32 core: one memory port, one ALU, and the IR/ALUOut/MDR registers.
- Decodes the opcode held in the instruction register.
- Steps each instruction through FETCH/DECODE/execute/writeback states.
- Stalls on a memory-ready handshake and bounds each memory wait with a timeout counter.
- Supported classes: R-type (0110011), load (0000011), store (0100011), branch (1100011).

Parameters:
- WAIT_LIMIT, 16: max cycles spent in one memory-wait state before timeout; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  7  IR[6:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  PC register write enable
- irwrite  output  1  IR (and old-PC) load
- adrsrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- regwrite  output  1  register file write
- alusrca  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 register
- alusrcb  output  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4
- aluop  output  2  00 = add, 01 = sub/compare, 10 = funct decode
- resultsrc  output  2  result select: 00 = ALUOut, 01 = MDR, 10 = ALU result
- immsel  output  2  immediate type select
- illegal  output  1  one-cycle pulse: unsupported opcode
- mem_timeout  output  1  one-cycle pulse: wait limit hit
- state  output  4  current state, for debug

Behaviour:
- State register and wait counter are the only storage; every output decodes combinationally from state, opcode, zero and mem_ready.
- Reset: rst sampled high forces state = FETCH and counter = 0. While rst is high, pc_en, irwrite, memread, memwrite, regwrite, illegal and mem_timeout are forced to 0. All other outputs take their FETCH values.
- Defaults in every state unless listed: all strobes 0, adrsrc = 0, alusrca = 00, alusrcb = 00, aluop = 00, resultsrc = 00.
- immsel, every state, from opcode: load = 00, store = 01, branch = 10, other = 00.
- FETCH:
  - memread = 1, alusrcb = 10, resultsrc = 10.
  - irwrite = pc_en = mem_ready.
  - mem_ready = 1 -> DECODE; otherwise hold.
- DECODE:
  - alusrca = 01, alusrcb = 01 (branch target into ALUOut).
  - load/store -> MEMADR; R-type -> EXECR; branch -> BEQ.
  - Any other opcode -> FETCH with illegal = 1 this cycle.
- MEMADR: alusrca = 10, alusrcb = 01. Load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: adrsrc = 1, memread = 1. mem_ready -> MEMWB; otherwise hold.
- MEMWB: resultsrc = 01, regwrite = 1 -> FETCH.
- MEMWRITE: adrsrc = 1, memwrite = 1. mem_ready -> FETCH; otherwise hold.
- EXECR: alusrca = 10, aluop = 10 -> ALUWB.
- ALUWB: regwrite = 1 -> FETCH.
- BEQ: alusrca = 10, aluop = 01, pc_en = zero -> FETCH.
- Latency with mem_ready tied high: R-type 4 cycles, load 5, store 4, branch 3, illegal opcode 2.
- Memory request rules: memread/memwrite stay asserted continuously until the cycle mem_ready = 1. The address source does not change during a wait.
- Wait counter:
  - Counts only in FETCH, MEMREAD and MEMWRITE while mem_ready = 0.
  - Clears on every state change and whenever mem_ready = 1.
- Timeout: if WAIT_LIMIT != 0 and the counter equals WAIT_LIMIT-1 with mem_ready = 0:
  - mem_timeout = 1 for that cycle, irwrite, pc_en and regwrite stay 0, next state = FETCH, counter cleared.
  - From FETCH this is a refetch of the same PC.
- Timeout and mem_ready in the same cycle: mem_ready wins, normal transition, no pulse.
- rst asserted mid-instruction: abandon the instruction, next state = FETCH. Any pending memwrite is dropped that cycle.
- Encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, ALUWB = 7, BEQ = 8. Unused codes -> FETCH next cycle with all strobes 0.

Test Plan:
- Reset then R-type (opcode = 0110011), mem_ready = 1 -> state sequence 0,1,6,7,0; regwrite = 1 only in state 7; aluop = 10 in state 6.
- Load, mem_ready low for 3 cycles in MEMREAD -> sequence 0,1,2,3,3,3,3,4,0; memread and adrsrc = 1 held through all 4 state-3 cycles; regwrite = 1 in state 4 with resultsrc = 01.
- Branch: zero = 1 then zero = 0 -> each takes 3 cycles; pc_en = 1 in BEQ only when zero = 1.
- Store with mem_ready held 0, WAIT_LIMIT = 16 -> memwrite high 16 cycles, mem_timeout pulse on the 16th, state 0 next, no regwrite.
- Opcode 0010011 -> illegal = 1 for one cycle in DECODE, back to FETCH after 2 cycles total.
- rst = 1 while in MEMWRITE with memwrite high -> all strobes 0 that cycle; state = 0 on the next edge.
